// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and sizing helper.
package serial_subtractor_pkg;

    // Raw state encodings, kept visible for anyone decoding the state register by value.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StFin  = ST_FIN
    } state_e;

    // Bits needed to count 0..n-1; never less than one so the counter always exists.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// START/DONE handshake and operand/result bus between a sequencer and the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_o;

    // Sequencer side: issues requests, observes status and result.
    modport master (
        output start, a, b, b_i,
        input  busy, done, d, b_o
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, b_i,
        output busy, done, d, b_o
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_i with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_i,
    output logic d,
    output logic b_o
);

    // Difference is plain parity; borrow when b exceeds a, or they tie and a borrow comes in.
    always_comb begin
        d   = a ^ b ^ b_i;
        b_o = (~a & b) | (~(a ^ b) & b_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// A request takes WIDTH cycles of RUN and one cycle of FIN, then returns to IDLE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned     CntW    = clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic             brw_q;

    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             busy_q;
    logic             done_q;

    logic cell_d;
    logic cell_bo;
    logic load;
    logic shift;
    logic last;

    full_subtractor u_cell (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .b_i (brw_q),
        .d   (cell_d),
        .b_o (cell_bo)
    );

    // Next-state and datapath strobes; START only matters while idle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                shift = 1'b1;
                if (cnt_q == CntLast) begin
                    last    = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, LSB-first shifting, borrow chaining and bit counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            r_sh_q <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            brw_q  <= bus.b_i;
            cnt_q  <= '0;
        end else if (shift) begin
            a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
            r_sh_q <= {cell_d, r_sh_q[WIDTH-1:1]};
            brw_q  <= cell_bo;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Result registers update only on the final bit, so they hold until the next FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= '0;
            bo_q <= 1'b0;
        end else if (last) begin
            d_q  <= {cell_d, r_sh_q[WIDTH-1:1]};
            bo_q <= cell_bo;
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != StIdle);
            done_q <= (state_d == StFin);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.b_o  = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: full-subtractor cell table, WIDTH=8 vectors and corner sequences,
// WIDTH=4 exhaustive sweep. Results are checked through per-DUT scoreboards.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    logic fs_a, fs_b, fs_bi, fs_d, fs_bo;

    full_subtractor u_fs (
        .a   (fs_a),
        .b   (fs_b),
        .b_i (fs_bi),
        .d   (fs_d),
        .b_o (fs_bo)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    typedef struct {
        logic a, b, bi, d, bo;
    } fs_vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
    } vec8_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t m8, m4;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard for the WIDTH=8 instance: every DONE must match the oldest request.
    always begin
        @(posedge clk);
        #1;
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut8 unexpected done: d=%0h b_o=%0b", bus8.d, bus8.b_o);
            end else begin
                m8 = q8.pop_front();
                check("dut8 d", 32'(bus8.d), 32'(m8.d));
                check("dut8 b_o", 32'(bus8.b_o), 32'(m8.bo));
            end
        end
    end

    // Scoreboard for the WIDTH=4 instance.
    always begin
        @(posedge clk);
        #1;
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut4 unexpected done: d=%0h b_o=%0b", bus4.d, bus4.b_o);
            end else begin
                m4 = q4.pop_front();
                check("dut4 d", 32'(bus4.d), 32'(m4.d));
                check("dut4 b_o", 32'(bus4.b_o), 32'(m4.bo));
            end
        end
    end

    // One-cycle START pulse on the WIDTH=8 bus; operands are scrambled right after accept.
    task automatic pulse8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic ebo);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.b_i   = bi;
        q8.push_back('{d: ed, bo: ebo});
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.b_i   = 1'($urandom);
    endtask

    // Called right after pulse8: DONE only after the 8th edge past accept, BUSY through it.
    task automatic timing8(input string name);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            check({name, " done"}, 32'(bus8.done), 32'(j == 8));
            check({name, " busy"}, 32'(bus8.busy), 32'd1);
        end
        @(posedge clk);
        #1;
        check({name, " busy end"}, 32'(bus8.busy), 32'd0);
        check({name, " done end"}, 32'(bus8.done), 32'd0);
    endtask

    fs_vec_t fsv[8];
    vec8_t   v8[8];
    int      dj[$];
    int      ndone;
    logic [4:0] r4;

    initial begin
        fsv[0] = '{0, 0, 0, 0, 0};
        fsv[1] = '{0, 0, 1, 1, 1};
        fsv[2] = '{0, 1, 0, 1, 1};
        fsv[3] = '{0, 1, 1, 0, 1};
        fsv[4] = '{1, 0, 0, 1, 0};
        fsv[5] = '{1, 0, 1, 0, 0};
        fsv[6] = '{1, 1, 0, 0, 0};
        fsv[7] = '{1, 1, 1, 1, 1};

        v8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        v8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        v8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        v8[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        v8[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
        v8[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        v8[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
        v8[7] = '{8'h5A, 8'hA5, 1'b1, 8'hB4, 1'b1};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.b_i = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.b_i = 1'b0;

        // Reset values.
        #2 rst_n = 1'b0;
        #10;
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst d", 32'(bus8.d), 32'd0);
        check("rst b_o", 32'(bus8.b_o), 32'd0);
        check("rst4 busy", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cell truth table.
        for (int i = 0; i < 8; i++) begin
            fs_a = fsv[i].a; fs_b = fsv[i].b; fs_bi = fsv[i].bi;
            #1;
            check($sformatf("fs[%0d] d", i), 32'(fs_d), 32'(fsv[i].d));
            check($sformatf("fs[%0d] b_o", i), 32'(fs_bo), 32'(fsv[i].bo));
        end

        // WIDTH=8 vector table.
        for (int i = 0; i < 8; i++) begin
            pulse8(v8[i].a, v8[i].b, v8[i].bi, v8[i].d, v8[i].bo);
            timing8($sformatf("v8[%0d]", i));
        end

        // START during RUN with new operands is dropped.
        pulse8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.b_i = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        ndone = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) begin
                ndone++;
                check("ignored-start done edge", 32'(j), 32'd5);
            end
        end
        check("ignored-start done count", 32'(ndone), 32'd1);

        // START held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h20; bus8.b = 8'h07; bus8.b_i = 1'b1;
        for (int k = 0; k < 3; k++) q8.push_back('{d: 8'h18, bo: 1'b0});
        @(posedge clk);
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) dj.push_back(j);
            if (j == 25) bus8.start = 1'b0;
        end
        check("held done count", 32'(dj.size()), 32'd3);
        if (dj.size() == 3) begin
            check("held first done", 32'(dj[0]), 32'd8);
            check("held spacing 1", 32'(dj[1] - dj[0]), 32'd10);
            check("held spacing 2", 32'(dj[2] - dj[1]), 32'd10);
        end

        // Leave a result with borrow set so the reset check sees a nonzero value cleared.
        pulse8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        timing8("pre-reset");

        // Asynchronous reset in cycle 4 of RUN aborts the operation.
        pulse8(8'h44, 8'h11, 1'b0, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus8.busy), 32'd0);
        check("abort done", 32'(bus8.done), 32'd0);
        check("abort d", 32'(bus8.d), 32'd0);
        check("abort b_o", 32'(bus8.b_o), 32'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        pulse8(8'h44, 8'h11, 1'b0, 8'h33, 1'b0);
        timing8("post-reset");

        // WIDTH=4 exhaustive sweep against the arithmetic model.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    r4 = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
                    @(negedge clk);
                    bus4.start = 1'b1;
                    bus4.a     = 4'(ai);
                    bus4.b     = 4'(bi);
                    bus4.b_i   = 1'(ci);
                    q4.push_back('{d: {4'b0, r4[3:0]}, bo: r4[4]});
                    @(negedge clk);
                    bus4.start = 1'b0;
                    bus4.a     = 4'($urandom);
                    bus4.b     = 4'($urandom);
                    for (int j = 1; j <= 4; j++) begin
                        @(posedge clk);
                        #1;
                        check("dut4 done timing", 32'(bus4.done), 32'(j == 4));
                    end
                    @(posedge clk);
                    #1;
                    check("dut4 busy end", 32'(bus4.busy), 32'd0);
                end
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("q8 drained", 32'(q8.size()), 32'd0);
        check("q4 drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
